la_capture_writer: RTL and testbench
====================================

// Module: la_capture_writer
// PURPOSE
//  Upstream producer of the logic-analyser capture memory. Samples the probed
//  bus every clock, run-length encodes it into {repeat_count, data} lines and
//  writes them to capture RAM: a circular pre-trigger area, a linear
//  post-trigger area, and a final bookmark line. The dump readback and replay
//  testbench generator consume the resulting RAM image.
// PARAMETERS
//  DATA_W     16  probed bus width (e.g. {cntb,cnta})
//  TS_W        8  repeat-count field width; max run = 2**TS_W-1
//  ADDR_W      6  capture RAM address width (64 lines)
//  PRE_DEPTH   8  pre-trigger ring lines at addr 0..PRE_DEPTH-1; power of 2, < 2**ADDR_W-2
// PORTS
//  clk            in   1               capture clock
//  rst_l          in   1               async reset, active low
//  arm            in   1               pulse: start a new capture (ignored unless IDLE/DONE)
//  data_in        in   DATA_W          probed bus, sampled every clk
//  trigger_match  in   1               from trigger matcher, level, sampled each clk
//  mem_we         out  1               RAM write strobe, one line per cycle
//  mem_addr       out  ADDR_W          RAM write address
//  mem_wdata      out  TS_W+DATA_W     {count, data}
//  busy           out  1               high in CLEAR/PRE/POST/BOOKMARK
//  done           out  1               high in DONE until next arm
// BEHAVIOUR
//  Reset (async, rst_l=0): state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, busy=0,
//   done=0, run regs cleared. Mid-operation reset aborts immediately, no further writes.
//  All outputs registered; a RAM write appears the cycle after its cause.
//  States: IDLE -arm-> CLEAR -> PRE -trig-> POST -> BOOKMARK -> DONE -arm-> CLEAR.
//  CLEAR: writes 0 to addr 0..2**ADDR_W-1, one per cycle (2**ADDR_W cycles); trigger
//   and data ignored; then PRE. Unused ring lines therefore read back 0.
//  Run-length (PRE and POST): run reg {cnt,val}. First cycle of PRE loads val=data_in,
//   cnt=1. Each later cycle: if data_in==val and cnt<2**TS_W-1 then cnt++ (no write);
//   else write {cnt,val} at current addr, load val=data_in, cnt=1.
//  PRE addressing: ring ptr starts 0, increments mod PRE_DEPTH after each write;
//   wrapped flag sets when ptr wraps 7->0 (PRE_DEPTH=8). Overwrites oldest entry.
//  Trigger: recognised only in PRE and not in PRE's first cycle. On recognition the
//   in-progress run (excluding the trigger-cycle sample) is written to the ring at ptr,
//   last_pre=ptr; the trigger-cycle sample starts the post run (cnt=1), state POST.
//   Pre area thus always holds >=1 entry. trigger_match in POST/CLEAR: ignored.
//  POST: writes go to PRE_DEPTH, PRE_DEPTH+1, ... 2**ADDR_W-2, same RLE rule.
//   After the write to 2**ADDR_W-2 the open run is discarded, state BOOKMARK.
//  BOOKMARK: one write at addr 2**ADDR_W-1, data = {TS_W'(wrapped), DATA_W'(last_pre)};
//   then DONE (done=1, busy=0, mem_we=0).
//  Saturation: run of identical data reaching cnt=2**TS_W-1 is written on the next
//   cycle and a fresh run (cnt=1) starts; no counter wrap.
//  arm while busy: ignored. arm in DONE: back to CLEAR, done drops next cycle.
//  mem_we never asserted in IDLE/DONE; exactly one line per write cycle.
// TESTING
//  T1 ramp data_in=0x0001,0x0102,.. trigger after 4 samples -> lines 0..3={01,data},
//   4..7=0, 8..62 post {01,..}, line 63 = 0x000003 (no wrap).
//  T2 trigger after 11 pre samples -> ring wraps, last_pre=2, line 63 = 0x010002, line
//   3 holds sample #4 (0-based: 3 overwritten by 11th? check oldest replaced).
//  T3 constant data_in for 300 cycles in POST -> lines {FF,d},{2D,d} (255+45), no wrap of cnt.
//  T4 trigger_match high in CLEAR and in PRE's first cycle -> ignored; recognised 2nd PRE cycle, line 0 = {01,first sample}.
//  T5 rst_l low mid-POST -> mem_we=0, busy=0 same cycle; re-arm gives full CLEAR.
//  T6 arm pulse during PRE/POST -> no effect; arm in DONE -> 64 zero writes then new capture.

Source files
------------

// File: rtl/la_capture_writer.sv
// ---------------------------------------------------------------------------
// la_capture_writer
//
// Front end of the logic-analyser capture memory. The probed bus is sampled
// on every clock and run-length encoded into {repeat_count, data} lines that
// are written to the capture RAM. A capture is laid out in three parts:
//   * a circular pre-trigger ring at addresses 0..PRE_DEPTH-1,
//   * a linear post-trigger area at PRE_DEPTH..2**ADDR_W-2,
//   * one bookmark line at 2**ADDR_W-1 holding {wrapped, last_pre}.
// Every capture begins by zeroing the whole RAM, so ring lines that are
// never written read back as 0.
//
// Ports
//   clk            capture clock
//   rst_l          asynchronous reset, active low
//   arm            pulse that starts a capture (accepted in IDLE or DONE only)
//   data_in        probed bus, sampled every clock
//   trigger_match  level from the trigger matcher
//   mem_we         RAM write strobe, one line per cycle
//   mem_addr       RAM write address
//   mem_wdata      RAM write data {count, data}
//   busy           high while a capture is producing writes
//   done           high once the capture is complete, until the next arm
// ---------------------------------------------------------------------------
module la_capture_writer #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 8,
  parameter int ADDR_W    = 6,
  parameter int PRE_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   arm,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   trigger_match,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [TS_W+DATA_W-1:0] mem_wdata,
  output logic                   busy,
  output logic                   done
);

  localparam int PTR_W = $clog2(PRE_DEPTH);
  localparam logic [TS_W-1:0]   CNT_MAX   = '1;
  localparam logic [ADDR_W-1:0] BOOK_ADDR = '1;
  localparam logic [ADDR_W-1:0] LAST_POST = BOOK_ADDR - 1'b1;
  localparam logic [ADDR_W-1:0] POST_BASE = ADDR_W'(PRE_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(PRE_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PRE,
    POST,
    BOOKMARK,
    DONE
  } state_t;

  state_t                   state, state_next;
  logic [ADDR_W-1:0]        clr_addr;
  logic                     pre_first;
  logic [TS_W-1:0]          run_cnt;
  logic [DATA_W-1:0]        run_val;
  logic [PTR_W-1:0]         ring_ptr;
  logic                     wrapped;
  logic [PTR_W-1:0]         last_pre;
  logic [ADDR_W-1:0]        post_addr;

  logic                     run_break;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [TS_W+DATA_W-1:0]   wr_data;

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and the write this cycle will cause. A run is closed when
  // the sample differs from it or when the counter is already saturated,
  // so the count field never wraps.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_addr    = clr_addr;
    wr_data    = '0;
    run_break  = (data_in != run_val) || (run_cnt == CNT_MAX);

    unique case (state)
      IDLE: begin
        if (arm) state_next = CLEAR;
      end
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        if (clr_addr == BOOK_ADDR) state_next = PRE;
      end
      PRE: begin
        // The first PRE cycle only opens the run; a trigger there is ignored
        // so the ring is guaranteed to hold at least one line.
        if (!pre_first && (trigger_match || run_break)) begin
          wr_en   = 1'b1;
          wr_addr = ADDR_W'(ring_ptr);
          wr_data = {run_cnt, run_val};
          if (trigger_match) state_next = POST;
        end
      end
      POST: begin
        if (run_break) begin
          wr_en   = 1'b1;
          wr_addr = post_addr;
          wr_data = {run_cnt, run_val};
          if (post_addr == LAST_POST) state_next = BOOKMARK;
        end
      end
      BOOKMARK: begin
        wr_en      = 1'b1;
        wr_addr    = BOOK_ADDR;
        wr_data    = {TS_W'(wrapped), DATA_W'(last_pre)};
        state_next = DONE;
      end
      DONE: begin
        if (arm) state_next = CLEAR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs. busy/done are registered from the
  // current state so they line up with the write that state produced:
  // the bookmark line is still shown with busy high, and done only rises
  // once mem_we has dropped.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      clr_addr  <= '0;
      pre_first <= 1'b0;
      run_cnt   <= '0;
      run_val   <= '0;
      ring_ptr  <= '0;
      wrapped   <= 1'b0;
      last_pre  <= '0;
      post_addr <= '0;
    end else begin
      mem_we <= wr_en;
      if (wr_en) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
      busy <= (state == CLEAR) || (state == PRE) ||
              (state == POST)  || (state == BOOKMARK);
      done <= (state == DONE);

      unique case (state)
        CLEAR: begin
          clr_addr  <= clr_addr + 1'b1;
          pre_first <= 1'b1;
          run_cnt   <= '0;
          run_val   <= '0;
          ring_ptr  <= '0;
          wrapped   <= 1'b0;
          last_pre  <= '0;
          post_addr <= POST_BASE;
        end
        PRE: begin
          if (pre_first) begin
            pre_first <= 1'b0;
            run_val   <= data_in;
            run_cnt   <= TS_W'(1);
          end else if (wr_en) begin
            run_val  <= data_in;
            run_cnt  <= TS_W'(1);
            ring_ptr <= ring_ptr + 1'b1;
            if (ring_ptr == PTR_LAST) wrapped <= 1'b1;
            if (trigger_match) last_pre <= ring_ptr;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        POST: begin
          if (wr_en) begin
            run_val   <= data_in;
            run_cnt   <= TS_W'(1);
            post_addr <= post_addr + 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_la_capture_writer.sv
// ---------------------------------------------------------------------------
// tb_la_capture_writer
//
// Drives complete captures into la_capture_writer and rebuilds the RAM image
// from the write port. The expected image is derived from the sample stream
// by grouping it into runs (at most 255 long), placing pre-trigger runs at
// line index mod 8 and post-trigger runs linearly from line 8, then adding
// the bookmark line.
// ---------------------------------------------------------------------------
module tb_la_capture_writer;

  localparam int DATA_W     = 16;
  localparam int TS_W       = 8;
  localparam int ADDR_W     = 6;
  localparam int PRE_DEPTH  = 8;
  localparam int DEPTH      = 64;
  localparam int POST_LINES = DEPTH - PRE_DEPTH - 1;
  localparam int STREAM_LEN = 4000;
  localparam int MAX_RUN    = 255;

  logic                   clk = 1'b0;
  logic                   rst_l;
  logic                   arm;
  logic [DATA_W-1:0]      data_in;
  logic                   trigger_match;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [TS_W+DATA_W-1:0] mem_wdata;
  logic                   busy;
  logic                   done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [TS_W+DATA_W-1:0] tb_ram  [DEPTH];
  logic [TS_W+DATA_W-1:0] exp_ram [DEPTH];
  logic [DATA_W-1:0]      stream  [STREAM_LEN];
  int                     wr_count;
  int                     bad_we;
  int                     exp_writes;

  la_capture_writer #(
    .DATA_W(DATA_W), .TS_W(TS_W), .ADDR_W(ADDR_W), .PRE_DEPTH(PRE_DEPTH)
  ) dut (
    .clk(clk), .rst_l(rst_l), .arm(arm), .data_in(data_in),
    .trigger_match(trigger_match), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Capture RAM as seen through the write port; writes are only legal
  // while busy is high and done is low.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tb_ram[mem_addr] = mem_wdata;
      wr_count = wr_count + 1;
      if (busy !== 1'b1 || done !== 1'b0) bad_we = bad_we + 1;
    end
  end

  // Guard against a design that never finishes.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int group_len(input int i, input int end_i);
    int len = 1;
    while (i + len < end_i && stream[i+len] == stream[i] && len < MAX_RUN)
      len++;
    return len;
  endfunction

  // Expected RAM image for a capture whose trigger arrives with sample t.
  task automatic build_model(input int t);
    int i, n, len;
    for (int a = 0; a < DEPTH; a++) exp_ram[a] = '0;
    i = 0;
    n = 0;
    while (i < t) begin
      len = group_len(i, t);
      exp_ram[n % PRE_DEPTH] = {TS_W'(len), stream[i]};
      n++;
      i += len;
    end
    i = t;
    for (int j = 0; j < POST_LINES; j++) begin
      len = group_len(i, STREAM_LEN);
      exp_ram[PRE_DEPTH + j] = {TS_W'(len), stream[i]};
      i += len;
    end
    exp_ram[DEPTH-1] = {TS_W'(n >= PRE_DEPTH ? 1 : 0), DATA_W'((n - 1) % PRE_DEPTH)};
    exp_writes = DEPTH + n + POST_LINES + 1;
  endtask

  task automatic gen_ramp();
    for (int k = 0; k < STREAM_LEN; k++) stream[k] = {8'(k), 8'(k + 1)};
  endtask

  task automatic gen_random();
    int k = 0;
    int len;
    logic [DATA_W-1:0] v;
    while (k < STREAM_LEN) begin
      v   = DATA_W'($urandom_range(0, 3));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 4);
      for (int r = 0; r < len && k < STREAM_LEN; r++) begin
        stream[k] = v;
        k++;
      end
    end
  endtask

  // One capture: arm, 64 clear cycles with junk on the inputs, then the
  // stream until done. abort_k >= 0 pulls reset in the middle instead.
  task automatic apply_stimulus(input int t, input bit early_trig,
                                input bit rand_arm, input int abort_k,
                                output bit finished);
    int wc;
    for (int a = 0; a < DEPTH; a++) tb_ram[a] = 24'hA5A5A5;
    wr_count = 0;
    bad_we   = 0;
    finished = 1'b0;
    @(negedge clk);
    arm           = 1'b1;
    data_in       = DATA_W'($urandom);
    trigger_match = early_trig;
    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_output("clear_busy",  32'(busy), 32'd1);
        check_output("clear_done",  32'(done), 32'd0);
        check_output("clear_we",    32'(mem_we), 32'd1);
        check_output("clear_addr0", 32'(mem_addr), 32'd0);
      end
      arm           = 1'b0;
      data_in       = DATA_W'($urandom);
      trigger_match = early_trig ? 1'b1 : 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < STREAM_LEN; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        finished = 1'b1;
        break;
      end
      if (k == abort_k) begin
        #2 rst_l = 1'b0;
        #1;
        check_output("abort_we",   32'(mem_we), 32'd0);
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        check_output("abort_addr", 32'(mem_addr), 32'd0);
        wc = wr_count;
        repeat (5) @(negedge clk);
        check_output("abort_no_writes", 32'(wr_count), 32'(wc));
        rst_l         = 1'b1;
        arm           = 1'b0;
        trigger_match = 1'b0;
        return;
      end
      data_in       = stream[k];
      trigger_match = (k == t) || (early_trig && k == 0) ||
                      (k > t && $urandom_range(0, 1) == 1);
      arm           = rand_arm && (k < t + 20) && ($urandom_range(0, 3) == 0);
    end
    arm           = 1'b0;
    trigger_match = 1'b0;
  endtask

  task automatic run_and_check(input string name, input int t,
                               input bit early_trig, input bit rand_arm);
    bit fin;
    build_model(t);
    apply_stimulus(t, early_trig, rand_arm, -1, fin);
    check_output({name, "_finished"}, 32'(fin), 32'd1);
    check_output({name, "_writes"}, 32'(wr_count), 32'(exp_writes));
    check_output({name, "_bad_we"}, 32'(bad_we), 32'd0);
    for (int a = 0; a < DEPTH; a++)
      check_output($sformatf("%s_line%0d", name, a), 32'(tb_ram[a]), 32'(exp_ram[a]));
    @(negedge clk);
    check_output({name, "_done"}, 32'(done), 32'd1);
    check_output({name, "_idle_busy"}, 32'(busy), 32'd0);
    check_output({name, "_idle_we"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    bit fin;
    rst_l         = 1'b0;
    arm           = 1'b0;
    data_in       = '0;
    trigger_match = 1'b0;
    wr_count      = 0;
    bad_we        = 0;
    repeat (3) @(negedge clk);
    check_output("rst_we",    32'(mem_we), 32'd0);
    check_output("rst_addr",  32'(mem_addr), 32'd0);
    check_output("rst_wdata", 32'(mem_wdata), 32'd0);
    check_output("rst_busy",  32'(busy), 32'd0);
    check_output("rst_done",  32'(done), 32'd0);
    rst_l = 1'b1;
    repeat (3) @(negedge clk);
    check_output("idle_we",   32'(mem_we), 32'd0);
    check_output("idle_busy", 32'(busy), 32'd0);

    // Ramp, trigger after four samples: no wrap, last_pre = 3.
    $display("[TB] ramp capture, short pre-trigger");
    gen_ramp();
    run_and_check("t1", 4, 1'b0, 1'b0);
    check_output("t1_line0",    32'(tb_ram[0]), 32'h010001);
    check_output("t1_line4",    32'(tb_ram[4]), 32'h000000);
    check_output("t1_bookmark", 32'(tb_ram[63]), 32'h000003);

    // Ramp, trigger after eleven samples: ring wraps, last_pre = 2.
    $display("[TB] ramp capture, wrapped ring");
    run_and_check("t2", 11, 1'b0, 1'b0);
    check_output("t2_bookmark", 32'(tb_ram[63]), 32'h010002);
    check_output("t2_line0",    32'(tb_ram[0]), 32'h010809);
    check_output("t2_line3",    32'(tb_ram[3]), 32'h010304);

    // 300 identical post samples split into 255 + 45.
    $display("[TB] saturating post run");
    for (int k = 2; k < 302; k++) stream[k] = 16'hBEEF;
    run_and_check("t3", 2, 1'b0, 1'b0);
    check_output("t3_sat_line",  32'(tb_ram[8]), 32'hFFBEEF);
    check_output("t3_tail_line", 32'(tb_ram[9]), 32'h2DBEEF);

    // Trigger held through CLEAR and the first PRE cycle.
    $display("[TB] early trigger ignored");
    for (int k = 0; k < STREAM_LEN; k++) stream[k] = DATA_W'($urandom);
    run_and_check("t4", 1, 1'b1, 1'b0);
    check_output("t4_line0", 32'(tb_ram[0]), 32'({8'h01, stream[0]}));

    // Reset in the middle of POST, then a full capture from scratch.
    $display("[TB] reset mid-capture");
    gen_random();
    apply_stimulus(5, 1'b0, 1'b0, 30, fin);
    gen_random();
    run_and_check("t5", 9, 1'b0, 1'b0);

    // arm pulses while busy, then back-to-back captures re-armed from DONE.
    $display("[TB] arm while busy and re-arm from done");
    for (int r = 0; r < 4; r++) begin
      gen_random();
      run_and_check($sformatf("t6_%0d", r), $urandom_range(1, 20), 1'b0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
